// File: rtl/sap1_program_loader.sv
// SAP-1 program loader: streams DEPTH program bytes plus a checksum byte into the
// program RAM over a valid/ready handshake, holding the CPU in reset until the image
// has been fully written and its checksum verified.
module sap1_program_loader #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   byte_count
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StCheck,
        StRun,
        StError
    } state_e;

    // Count value at which the transfer being accepted is the last program byte.
    localparam logic [ADDR_W:0] LastIdx = (ADDR_W + 1)'(DEPTH - 1);

    state_e            state_q;
    logic [DATA_W-1:0] sum_q;
    logic              xfer;

    assign xfer = in_valid && in_ready;

    // Loader FSM; every output is registered here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            sum_q      <= '0;
            in_ready   <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            byte_count <= '0;
        end else begin
            // Write strobe is a single-cycle pulse; address/data keep their last values.
            ram_we <= 1'b0;
            unique case (state_q)
                StIdle, StRun, StError: begin
                    if (start) begin
                        state_q    <= StLoad;
                        sum_q      <= '0;
                        byte_count <= '0;
                        in_ready   <= 1'b1;
                        cpu_hold   <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                    end
                end
                StLoad: begin
                    if (xfer) begin
                        ram_we     <= 1'b1;
                        ram_addr   <= byte_count[ADDR_W-1:0];
                        ram_wdata  <= in_data;
                        sum_q      <= sum_q + in_data;
                        byte_count <= byte_count + 1'b1;
                        if (byte_count == LastIdx) begin
                            state_q <= StCheck;
                        end
                    end
                end
                StCheck: begin
                    // Checksum byte is compared only, never written to RAM.
                    if (xfer) begin
                        in_ready <= 1'b0;
                        if (in_data == sum_q) begin
                            state_q  <= StRun;
                            cpu_hold <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            state_q <= StError;
                            error   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    in_ready <= 1'b0;
                    cpu_hold <= 1'b1;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sap1_program_loader.sv
// Self-checking bench for sap1_program_loader: behavioural RAM, image/checksum model,
// directed scenarios plus randomized images and source stalls.
module tb_sap1_program_loader;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   byte_count;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  mem [DEPTH];
    int unsigned wr_cnt = 0;

    sap1_program_loader #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .error     (error),
        .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    // Program RAM model: captures on the edge after the strobe is presented.
    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
            wr_cnt        <= wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Runs one full load. mode: 0 continuous valid, 1 alternating valid, 2 random valid.
    // exp_edges counts the start edge as 1; negative skips the latency check.
    // start_poke >= 0 pulses start when that many bytes have been accepted.
    task automatic run_load(input logic [7:0] img [DEPTH], input logic [7:0] chk,
                            input int mode, input int exp_edges, input int start_poke);
        int          edges;
        int          idx;
        int          bad;
        bit          xfer;
        bit          prog;
        bit          ph;
        bit          poked;
        logic [7:0]  sum;
        bit          exp_ok;
        int unsigned wr0;
        sum = 8'h00;
        for (int i = 0; i < DEPTH; i++) sum = sum + img[i];
        exp_ok = (sum == chk);

        @(posedge clk); #1;
        start    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        edges = 1;
        wr0   = wr_cnt;
        check("ready_after_start", in_ready, 1);
        check("hold_after_start", cpu_hold, 1);
        check("count_after_start", byte_count, 0);

        idx   = 0;
        ph    = 1'b1;
        poked = 1'b0;
        while (!(done || error) && edges < 300) begin
            case (mode)
                0:       in_valid = 1'b1;
                1:       in_valid = ph;
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            in_data = (idx < DEPTH) ? img[idx] : chk;
            if (start_poke >= 0 && idx == start_poke && !poked) begin
                check("count_at_poke", byte_count, idx);
                start = 1'b1;
                poked = 1'b1;
            end
            xfer = in_valid && in_ready;
            prog = (idx < DEPTH);
            @(posedge clk); #1;
            edges++;
            ph    = !ph;
            start = 1'b0;
            if (xfer) begin
                check("we_after_xfer", ram_we, prog);
                if (prog) begin
                    check("waddr", ram_addr, idx);
                    check("wdata", ram_wdata, img[idx]);
                end
                idx++;
            end else begin
                check("we_no_xfer", ram_we, 0);
            end
        end
        in_valid = 1'b0;

        check("load_finished", done || error, 1);
        if (exp_edges > 0) check("latency", edges, exp_edges);
        check("done", done, exp_ok);
        check("error", error, !exp_ok);
        check("cpu_hold", cpu_hold, !exp_ok);
        check("ready_low_after", in_ready, 0);
        check("byte_count_final", byte_count, DEPTH);
        check("write_count", wr_cnt - wr0, DEPTH);
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== img[i]) bad++;
        check("ram_image", bad, 0);
    endtask

    initial begin
        logic [7:0] img [DEPTH];
        logic [7:0] s;
        int unsigned w0;
        int          we_seen;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_wdata", ram_wdata, 0);
        check("rst_cpu_hold", cpu_hold, 1);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_byte_count", byte_count, 0);
        reset = 1'b1;

        // in_valid in IDLE is ignored
        w0       = wr_cnt;
        we_seen  = 0;
        in_valid = 1'b1;
        in_data  = 8'hAA;
        repeat (4) begin
            @(posedge clk); #1;
            if (ram_we) we_seen++;
        end
        in_valid = 1'b0;
        check("idle_we_pulses", we_seen, 0);
        check("idle_writes", wr_cnt - w0, 0);
        check("idle_ready", in_ready, 0);

        // Good image 0x01..0x10, checksum 0x88
        for (int i = 0; i < DEPTH; i++) img[i] = 8'(i + 1);
        run_load(img, 8'h88, 0, 18, -1);
        // Bad checksum, then recover with a good one
        run_load(img, 8'h87, 0, 18, -1);
        run_load(img, 8'h88, 0, 18, -1);

        // Asynchronous reset mid-cycle while running
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        check("async_rst_hold", cpu_hold, 1);
        check("async_rst_done", done, 0);
        check("async_rst_ready", in_ready, 0);
        check("async_rst_count", byte_count, 0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Stalled source, 0xFF x16 wraps to 0xF0
        for (int i = 0; i < DEPTH; i++) img[i] = 8'hFF;
        run_load(img, 8'hF0, 1, 34, -1);

        // start mid-LOAD is ignored
        for (int i = 0; i < DEPTH; i++) img[i] = 8'(8'h30 + i);
        s = 8'h00;
        for (int i = 0; i < DEPTH; i++) s = s + img[i];
        run_load(img, s, 0, 18, 5);

        // Reset mid-load at byte_count 9, then fresh image from address 0
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_data = 8'(8'h50 + i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("count_before_abort", byte_count, 9);
        #2;
        reset = 1'b0;
        #1;
        check("abort_hold", cpu_hold, 1);
        check("abort_ready", in_ready, 0);
        check("abort_count", byte_count, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_idle_ready", in_ready, 0);
        for (int i = 0; i < DEPTH; i++) img[i] = 8'(8'hA0 + i);
        s = 8'h00;
        for (int i = 0; i < DEPTH; i++) s = s + img[i];
        run_load(img, s, 0, 18, -1);

        // Randomized images, stalls and checksums
        for (int t = 0; t < 8; t++) begin
            s = 8'h00;
            for (int i = 0; i < DEPTH; i++) begin
                img[i] = 8'($urandom);
                s      = s + img[i];
            end
            if ($urandom_range(0, 1) == 1) s = s ^ 8'($urandom_range(1, 255));
            run_load(img, s, 2, -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sap1_program_loader.md
# sap1_program_loader

Front-end loader that fills the SAP-1 16×8 program RAM from a byte stream before the CPU runs. It accepts 16 program bytes plus one checksum byte over a valid/ready handshake and writes each byte to the RAM write port. It holds the CPU in reset until a full image has loaded and its checksum matches, then releases the CPU. It is the writer end of the RAM interface that the CPU's memory path reads.

## Interface
- `DEPTH`, 16: number of program bytes per image. This is the RAM depth.
- `ADDR_W`, 4: RAM address width. Requires 2^ADDR_W == DEPTH.
- `DATA_W`, 8: byte width. This is the `w_bus` width.
- `clk`: input, 1 bit. Single clock. All state changes on the rising edge.
- `reset`: input, 1 bit. Asynchronous, active-low.
- `start`: input, 1 bit. Single-cycle request to begin loading an image.
- `in_valid`: input, 1 bit. Source has a byte on `in_data`.
- `in_data`: input, DATA_W bits. Program or checksum byte.
- `in_ready`: output, 1 bit. Loader accepts a byte this cycle.
- `ram_we`: output, 1 bit. RAM write strobe.
- `ram_addr`: output, ADDR_W bits. RAM write address.
- `ram_wdata`: output, DATA_W bits. RAM write data.
- `cpu_hold`: output, 1 bit. Active-high reset for the CPU.
- `done`: output, 1 bit. Image loaded and verified; CPU running.
- `error`: output, 1 bit. Checksum mismatch on the last image.
- `byte_count`: output, ADDR_W+1 bits. Number of program bytes accepted in the current load.

## Operation
- States:
  - IDLE: waiting for `start`; CPU held.
  - LOAD: accepting the DEPTH program bytes.
  - CHECK: accepting the checksum byte.
  - RUN: verified; CPU released.
  - ERROR: checksum failed; CPU held.
- Handshake: a byte transfers on a rising edge where `in_valid && in_ready` is true. `in_ready` is a registered output. It is 1 only in LOAD and CHECK.
- IDLE → LOAD when `start` is 1. This also clears `byte_count`, the write pointer and the running sum, and sets `cpu_hold`=1, `done`=0 and `error`=0.
- LOAD: each transfer does the following:
  - writes `in_data` to address `byte_count[ADDR_W-1:0]`;
  - adds `in_data` to the running sum, 8-bit and wrapping mod 256;
  - increments `byte_count`.
- LOAD → CHECK on the transfer that brings `byte_count` to DEPTH.
- CHECK: on the transfer, the loader compares `in_data` with the running sum. The checksum byte is never written to RAM.
  - If equal: go to RUN, with `cpu_hold`=0 and `done`=1.
  - If not equal: go to ERROR, with `error`=1 and `cpu_hold` staying 1.
- RUN or ERROR → LOAD when `start` is 1. `cpu_hold` is reasserted on that same edge, and `done` and `error` are cleared.
- `start` is ignored in LOAD and CHECK.
- `in_valid` outside LOAD and CHECK is ignored. No transfer occurs and no write is made.
- Write-port idle values: when `ram_we`=0, `ram_addr` and `ram_wdata` hold their last values. The RAM must ignore them.
- Reset values, applied asynchronously when `reset`=0:
  - state = IDLE;
  - `in_ready`=0, `ram_we`=0, `ram_addr`=0, `ram_wdata`=0;
  - `cpu_hold`=1, `done`=0, `error`=0, `byte_count`=0;
  - running sum = 0.
- Reset mid-load: the RAM keeps any bytes already written. The next `start` reloads the RAM from address 0.

## Timing
- Write latency:
  - For a transfer at edge N, `ram_we`=1 with the matching `ram_addr` and `ram_wdata` is visible in the cycle after edge N.
  - The RAM captures the byte at edge N+1.
  - `ram_we` is a one-cycle pulse per transfer.
- `in_ready` rises in the cycle after the `start` edge.
- `in_ready` stays 1 through LOAD and CHECK, so back-to-back transfers run at one byte per clock.
- `in_ready` falls in the cycle after the checksum transfer.
- A minimal load takes DEPTH+1 transfer cycles plus 1 cycle for the `start` edge. With continuous `in_valid`, `done` rises 18 cycles after the `start` edge when DEPTH=16.
- `cpu_hold` falls on the same edge that `done` rises. `cpu_hold` and `done` never both read 1 in the same cycle.
- The last program byte's `ram_we` pulse lines up with the CHECK cycle, so it completes before `cpu_hold` deasserts.
- `reset` deassertion is synchronised externally. The first edge after release already sees IDLE.

## Test plan
- Reset check: drive `reset`=0 mid-cycle → all outputs reach their reset values immediately. `cpu_hold`=1 and `in_ready`=0.
- Good image:
  - Stimulus: `start`, then bytes 0x01..0x10 back-to-back, then checksum 0x88.
  - RAM must hold addresses 0..15 = 0x01..0x10.
  - `done`=1 and `cpu_hold`=0 exactly 18 cycles after the `start` edge.
  - `byte_count`=16.
- Bad checksum: same 16 bytes, checksum 0x87 → `error`=1, `cpu_hold`=1, `done`=0. Then `start` plus a good image → `done`=1 and `error`=0.
- Stalled source: `in_valid` toggled 1/0 every other cycle with bytes 0xFF×16 and checksum 0xF0 (sum wraps mod 256).
  - Exactly 16 writes occur.
  - `done`=1 after 34 cycles.
- Ignored inputs:
  - `start` pulsed mid-LOAD at `byte_count`=5 → no restart; load completes normally.
  - `in_valid`=1 in IDLE with data 0xAA → no `ram_we` pulse.
- Reset mid-load: `reset` asserted at `byte_count`=9 → state IDLE and `cpu_hold`=1. A fresh `start` plus a full image rewrites from address 0 and reaches `done`=1.
